// File: rtl/hpdmc_ddr_deser_if.sv
// Half-word input stream and full-word output stream for the DDR deserializer.
// master = producer/consumer side, slave = the deserializer.
interface hpdmc_ddr_deser_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_first;
  logic [DW-1:0] in_data;

  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] out_data;

  logic [LW-1:0] level;
  logic          overflow;
  logic          misalign;

  modport master (
    output in_valid, in_first, in_data, out_ready,
    input  out_valid, out_data, level, overflow, misalign
  );

  modport slave (
    input  in_valid, in_first, in_data, out_ready,
    output out_valid, out_data, level, overflow, misalign
  );
endinterface

// File: rtl/hpdmc_ddr_deser.sv
// Pairs DDR half-words (low then high) into 2*DW words and queues them in a FWFT FIFO.
// Latency 1 cycle from the high half to out_valid; a push into a full FIFO without a pop is dropped and flagged.
module hpdmc_ddr_deser #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  hpdmc_ddr_deser_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic            phase;
  logic [DW-1:0]   low_q;
  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic            overflow_q;
  logic            misalign_q;

  logic pop;
  logic push_req;
  logic full;
  logic push;

  always_comb begin
    pop      = (level_q != '0) && bus.out_ready;
    push_req = bus.in_valid && !bus.in_first && phase;
    full     = (level_q == FULL);
    // A full FIFO still accepts the word when the head leaves on the same edge.
    push     = push_req && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      low_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (clr) begin
      phase      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        // in_first restarts the pairing; a pending low half is stale.
        if (bus.in_first || !phase) begin
          low_q <= bus.in_data;
          phase <= 1'b1;
          if (bus.in_first && phase)
            misalign_q <= 1'b1;
        end else begin
          phase <= 1'b0;
        end
      end

      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push_req && full && !pop)
        overflow_q <= 1'b1;

      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr)
      mem[wr_ptr] <= {bus.in_data, low_q};
  end

  // Gating by occupancy keeps out_data at zero while empty or in reset.
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = (level_q != '0) ? mem[rd_ptr] : '0;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_hpdmc_ddr_deser.sv
// Bench for hpdmc_ddr_deser: directed scenarios plus randomized traffic against a queue-based model.
module tb_hpdmc_ddr_deser;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;
  logic clr;

  hpdmc_ddr_deser_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  hpdmc_ddr_deser #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference model: words waiting for the consumer, pairing state and flags.
  logic [2*DW-1:0] m_q[$];
  logic            m_phase;
  logic [DW-1:0]   m_low;
  logic            m_ovf;
  logic            m_mis;

  task automatic model_reset();
    m_q.delete();
    m_phase = 1'b0;
    m_low   = '0;
    m_ovf   = 1'b0;
    m_mis   = 1'b0;
  endtask

  // Drive one cycle of inputs, advance to 1 time unit after the edge, update model.
  task automatic cycle(input logic v, input logic f, input logic [DW-1:0] d,
                       input logic rdy, input logic c);
    int              sz;
    logic            pop;
    logic            do_push;
    logic [2*DW-1:0] word;
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.in_data   = d;
    bus.out_ready = rdy;
    clr           = c;
    @(posedge clk);
    #1;
    if (c) begin
      m_q.delete();
      m_phase = 1'b0;
      m_ovf   = 1'b0;
      m_mis   = 1'b0;
    end else begin
      do_push = 1'b0;
      word    = '0;
      if (v) begin
        if (f) begin
          if (m_phase) m_mis = 1'b1;
          m_low   = d;
          m_phase = 1'b1;
        end else if (!m_phase) begin
          m_low   = d;
          m_phase = 1'b1;
        end else begin
          word    = {d, m_low};
          do_push = 1'b1;
          m_phase = 1'b0;
        end
      end
      sz  = m_q.size();
      pop = (sz > 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (do_push) begin
        if (sz == DEPTH && !pop) m_ovf = 1'b1;
        else m_q.push_back(word);
      end
    end
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.out_ready = 1'b0;
    clr           = 1'b0;
  endtask

  task automatic push_word(input logic [2*DW-1:0] w, input logic rdy_hi);
    cycle(1'b1, 1'b1, w[DW-1:0], 1'b0, 1'b0);
    cycle(1'b1, 1'b0, w[2*DW-1:DW], rdy_hi, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== '0 || bus.out_data !== '0 ||
        bus.overflow !== 1'b0 || bus.misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b level=%0d data=%h ovf=%b mis=%b required all zero",
               bus.out_valid, bus.level, bus.out_data, bus.overflow, bus.misalign);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== '0) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b level=%0d required 0/0", bus.out_valid, bus.level);
    end
  endtask

  task automatic test_basic();
    cycle(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_low_only: out_valid=%b required 0", bus.out_valid);
    end
    cycle(1'b1, 1'b0, 16'hABCD, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hABCD1234 || bus.level !== LW'(1)) begin
      n_fail++;
      $display("FAIL basic_pair: valid=%b data=%h level=%0d required 1 abcd1234 1",
               bus.out_valid, bus.out_data, bus.level);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== '0) begin
      n_fail++;
      $display("FAIL basic_pop: valid=%b level=%0d required 0 0", bus.out_valid, bus.level);
    end
  endtask

  task automatic test_overflow();
    logic [2*DW-1:0] w [5];
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      push_word(w[i], 1'b0);
    end
    n_checks++;
    if (bus.level !== LW'(DEPTH) || bus.overflow !== 1'b1 || bus.out_data !== w[0]) begin
      n_fail++;
      $display("FAIL overflow_full: level=%0d ovf=%b data=%h required %0d 1 %h",
               bus.level, bus.overflow, bus.out_data, DEPTH, w[0]);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    n_checks++;
    if (bus.out_data !== w[0]) begin
      n_fail++;
      $display("FAIL overflow_hold: data=%h required %h", bus.out_data, w[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== w[i]) begin
        n_fail++;
        $display("FAIL overflow_drain%0d: valid=%b data=%h required 1 %h",
                 i, bus.out_valid, bus.out_data, w[i]);
      end
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_empty: valid=%b ovf=%b required 0 1", bus.out_valid, bus.overflow);
    end
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_full_push_pop();
    logic [2*DW-1:0] w [7];
    for (int i = 0; i < 7; i++) w[i] = $urandom;
    // Offset the pointers so the later fill wraps.
    push_word(w[0], 1'b0);
    push_word(w[1], 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 2; i < 6; i++) push_word(w[i], 1'b0);
    cycle(1'b1, 1'b1, w[6][DW-1:0], 1'b0, 1'b0);
    cycle(1'b1, 1'b0, w[6][2*DW-1:DW], 1'b1, 1'b0);
    n_checks++;
    if (bus.level !== LW'(DEPTH) || bus.overflow !== 1'b0 || bus.out_data !== w[3]) begin
      n_fail++;
      $display("FAIL fullpp_level: level=%0d ovf=%b data=%h required %0d 0 %h",
               bus.level, bus.overflow, bus.out_data, DEPTH, w[3]);
    end
    for (int i = 3; i < 7; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== w[i]) begin
        n_fail++;
        $display("FAIL fullpp_order%0d: valid=%b data=%h required 1 %h",
                 i, bus.out_valid, bus.out_data, w[i]);
      end
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpp_empty: valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_misalign();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
    n_checks++;
    if (bus.misalign !== 1'b1 || bus.level !== '0) begin
      n_fail++;
      $display("FAIL misalign_restart: mis=%b level=%0d required 1 0", bus.misalign, bus.level);
    end
    cycle(1'b1, 1'b0, 16'h3333, 1'b0, 1'b0);
    n_checks++;
    if (bus.level !== LW'(1) || bus.out_data !== 32'h33332222 || bus.misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_word: level=%0d data=%h mis=%b required 1 33332222 1",
               bus.level, bus.out_data, bus.misalign);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_clr();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) push_word($urandom, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0);
    n_checks++;
    if (bus.level !== LW'(2) || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_setup: level=%0d ovf=%b required 2 1", bus.level, bus.overflow);
    end
    cycle(1'b1, 1'b0, 16'hBBBB, 1'b1, 1'b1);
    n_checks++;
    if (bus.level !== '0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_flush: level=%0d valid=%b ovf=%b mis=%b required 0 0 0 0",
               bus.level, bus.out_valid, bus.overflow, bus.misalign);
    end
    cycle(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h8888, 1'b0, 1'b0);
    n_checks++;
    if (bus.level !== LW'(1) || bus.out_data !== 32'h88887777) begin
      n_fail++;
      $display("FAIL clr_phase: level=%0d data=%h required 1 88887777", bus.level, bus.out_data);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midburst();
    cycle(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h4545, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    n_checks++;
    if (bus.level !== LW'(1) || bus.misalign !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: level=%0d mis=%b required 1 1", bus.level, bus.misalign);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== '0 || bus.out_data !== '0 || bus.misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: valid=%b level=%0d data=%h mis=%b required 0 0 0 0",
               bus.out_valid, bus.level, bus.out_data, bus.misalign);
    end
    #1 rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
    n_checks++;
    if (bus.level !== '0) begin
      n_fail++;
      $display("FAIL rstmid_lowhalf: level=%0d required 0", bus.level);
    end
    cycle(1'b1, 1'b0, 16'h6666, 1'b0, 1'b0);
    n_checks++;
    if (bus.level !== LW'(1) || bus.out_data !== 32'h66665555) begin
      n_fail++;
      $display("FAIL rstmid_pair: level=%0d data=%h required 1 66665555", bus.level, bus.out_data);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      logic rdy_bias;
      rdy_bias = ((i / 100) % 2) == 0;
      cycle($urandom_range(0, 3) != 0,
            $urandom_range(0, 9) == 0,
            DW'($urandom),
            rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            $urandom_range(0, 199) == 0);
      n_checks++;
      if (bus.out_valid !== (m_q.size() != 0) || bus.level !== LW'(m_q.size()) ||
          bus.overflow !== m_ovf || bus.misalign !== m_mis ||
          (m_q.size() != 0 && bus.out_data !== m_q[0])) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cyc%0d: valid=%b level=%0d ovf=%b mis=%b data=%h required level=%0d ovf=%b mis=%b data=%h",
                   i, bus.out_valid, bus.level, bus.overflow, bus.misalign, bus.out_data,
                   m_q.size(), m_ovf, m_mis, (m_q.size() != 0) ? m_q[0] : '0);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_misalign();
    test_clr();
    test_reset_midburst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
